// File: rtl/bist_signature_analyzer_if.sv
// Bus between a BIST controller and the signature analyzer: session control,
// the serial response stream, the golden value and the observed results.
// Optional abort strobe present when BIST_SA_ABORT_EN is defined.
interface bist_signature_analyzer_if #(
    parameter int unsigned SIG_W    = 8,
    parameter int unsigned NUM_BITS = 64,
    parameter int unsigned CW       = $clog2(NUM_BITS + 1)
);
    logic             start;
`ifdef BIST_SA_ABORT_EN
    logic             abort;
`endif
    logic             bit_valid;
    logic             bit_in;
    logic [SIG_W-1:0] golden;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CW-1:0]    bit_count;

    modport master (
        output start,
`ifdef BIST_SA_ABORT_EN
        output abort,
`endif
        output bit_valid, bit_in, golden,
        input  busy, done, pass, signature, bit_count
    );

    modport slave (
        input  start,
`ifdef BIST_SA_ABORT_EN
        input  abort,
`endif
        input  bit_valid, bit_in, golden,
        output busy, done, pass, signature, bit_count
    );
endinterface

// File: rtl/bist_signature_analyzer.sv
// Output-response analyzer for the LFSR -> scan chain BIST path. Compacts the
// serial scan_out stream into a Galois SISR and, after NUM_BITS accepted bits,
// compares the signature against golden and reports pass/fail.
// Optional feature: define BIST_SA_ABORT_EN to add an abort strobe that returns
// RUN/CHECK to IDLE while freezing signature and bit_count.
module bist_signature_analyzer #(
    parameter int unsigned     SIG_W    = 8,
    parameter logic [SIG_W-1:0] POLY    = 8'h1D,
    parameter logic [SIG_W-1:0] SEED    = 8'h00,
    parameter int unsigned     NUM_BITS = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    bist_signature_analyzer_if.slave    bus
);
    localparam int unsigned CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t           state, state_next;
    logic [SIG_W-1:0] sig, sig_next, sig_shift;
    logic [CW-1:0]    cnt, cnt_next, cnt_inc;
    logic             busy, busy_next;
    logic             done, done_next;
    logic             pass, pass_next;
    logic             abort_hit;

`ifdef BIST_SA_ABORT_EN
    assign abort_hit = bus.abort && (state == RUN || state == CHECK);
`else
    assign abort_hit = 1'b0;
`endif

    // SISR step and saturating bit counter for the incoming bit
    always_comb begin
        sig_shift = {sig[SIG_W-2:0], 1'b0}
                  ^ (sig[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, bus.bit_in};
        cnt_inc   = (cnt == CW'(NUM_BITS)) ? cnt : cnt + CW'(1);
    end

    // Next-state and next-output decode; abort beats start, start beats bit_valid
    always_comb begin
        state_next = state;
        sig_next   = sig;
        cnt_next   = cnt;
        busy_next  = busy;
        done_next  = done;
        pass_next  = pass;
        if (abort_hit) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            pass_next  = 1'b0;
        end else if (bus.start) begin
            state_next = RUN;
            sig_next   = SEED;
            cnt_next   = '0;
            busy_next  = 1'b1;
            done_next  = 1'b0;
            pass_next  = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.bit_valid) begin
                        sig_next = sig_shift;
                        cnt_next = cnt_inc;
                        if (cnt == CW'(NUM_BITS - 1)) begin
                            state_next = CHECK;
                        end
                    end
                end
                CHECK: begin
                    pass_next  = (sig == bus.golden);
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = DONE;
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sig   <= SEED;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            state <= state_next;
            sig   <= sig_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
            done  <= done_next;
            pass  <= pass_next;
        end
    end

    assign bus.signature = sig;
    assign bus.bit_count = cnt;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer: three instances (NUM_BITS = 8, 9
// and 64) share clock, reset, bit_in and golden; start/bit_valid are per
// instance. Abort scenario included when BIST_SA_ABORT_EN is defined.
module tb_bist_signature_analyzer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic [7:0] golden;
    logic       start_v [3];
    logic       valid_v [3];
    int         checks = 0;
    int         errors = 0;

    bist_signature_analyzer_if #(.SIG_W(8), .NUM_BITS(8))  if8  ();
    bist_signature_analyzer_if #(.SIG_W(8), .NUM_BITS(9))  if9  ();
    bist_signature_analyzer_if #(.SIG_W(8), .NUM_BITS(64)) if64 ();

    assign if8.start      = start_v[0];
    assign if9.start      = start_v[1];
    assign if64.start     = start_v[2];
    assign if8.bit_valid  = valid_v[0];
    assign if9.bit_valid  = valid_v[1];
    assign if64.bit_valid = valid_v[2];
    assign if8.bit_in     = bit_in;
    assign if9.bit_in     = bit_in;
    assign if64.bit_in    = bit_in;
    assign if8.golden     = golden;
    assign if9.golden     = golden;
    assign if64.golden    = golden;

`ifdef BIST_SA_ABORT_EN
    logic abort64 = 1'b0;
    assign if8.abort  = 1'b0;
    assign if9.abort  = 1'b0;
    assign if64.abort = abort64;
`endif

    bist_signature_analyzer #(.SIG_W(8), .POLY(8'h1D), .SEED(8'h00), .NUM_BITS(8))
        dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    bist_signature_analyzer #(.SIG_W(8), .POLY(8'h1D), .SEED(8'h00), .NUM_BITS(9))
        dut9 (.clk(clk), .rst_n(rst_n), .bus(if9));
    bist_signature_analyzer #(.SIG_W(8), .POLY(8'h1D), .SEED(8'h00), .NUM_BITS(64))
        dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bit(input int d, input logic b);
        valid_v[d] = 1'b1;
        bit_in     = b;
        tick();
        valid_v[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    logic [7:0] exp8 [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic       bits5 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] sig5 [5]  = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16};

    initial begin
        rst_n  = 1'b0;
        bit_in = 1'b0;
        golden = 8'h00;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            valid_v[i] = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_sig",  32'(if64.signature), 32'h00);
        chk("rst_cnt",  32'(if64.bit_count), 32'd0);
        chk("rst_busy", 32'(if64.busy), 32'd0);
        chk("rst_done", 32'(if64.done), 32'd0);
        chk("rst_pass", 32'(if64.pass), 32'd0);

        // bit_valid ignored in IDLE
        push_bit(2, 1'b1);
        chk("idle_ignore_sig", 32'(if64.signature), 32'h00);
        chk("idle_ignore_cnt", 32'(if64.bit_count), 32'd0);

        // NUM_BITS=8, eight ones
        golden = 8'hFF;
        pulse_start(0);
        chk("n8_busy_start", 32'(if8.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            push_bit(0, 1'b1);
            chk($sformatf("n8_sig%0d", i), 32'(if8.signature), 32'(exp8[i]));
        end
        chk("n8_cnt", 32'(if8.bit_count), 32'd8);
        chk("n8_done_in_check", 32'(if8.done), 32'd0);
        chk("n8_busy_in_check", 32'(if8.busy), 32'd1);
        tick();
        chk("n8_done", 32'(if8.done), 32'd1);
        chk("n8_pass", 32'(if8.pass), 32'd1);
        chk("n8_busy_end", 32'(if8.busy), 32'd0);
        push_bit(0, 1'b1);
        chk("n8_hold_sig", 32'(if8.signature), 32'hFF);
        chk("n8_hold_cnt", 32'(if8.bit_count), 32'd8);
        chk("n8_hold_done", 32'(if8.done), 32'd1);

        // NUM_BITS=9, 1 then eight zeros exercises the feedback taps
        golden = 8'h1D;
        pulse_start(1);
        push_bit(1, 1'b1);
        for (int i = 0; i < 7; i++) push_bit(1, 1'b0);
        chk("n9_sig8", 32'(if9.signature), 32'h80);
        push_bit(1, 1'b0);
        chk("n9_sig9", 32'(if9.signature), 32'h1D);
        chk("n9_cnt", 32'(if9.bit_count), 32'd9);
        tick();
        chk("n9_done", 32'(if9.done), 32'd1);
        chk("n9_pass", 32'(if9.pass), 32'd1);

        // NUM_BITS=64, zeros against golden 0x01 -> fail
        golden = 8'h01;
        pulse_start(2);
        for (int i = 0; i < 63; i++) push_bit(2, 1'b0);
        chk("n64_cnt63", 32'(if64.bit_count), 32'd63);
        chk("n64_busy63", 32'(if64.busy), 32'd1);
        push_bit(2, 1'b0);
        tick();
        chk("n64_sig", 32'(if64.signature), 32'h00);
        chk("n64_cnt", 32'(if64.bit_count), 32'd64);
        chk("n64_done", 32'(if64.done), 32'd1);
        chk("n64_pass", 32'(if64.pass), 32'd0);
        pulse_start(2);
        chk("restart_done", 32'(if64.done), 32'd0);
        chk("restart_busy", 32'(if64.busy), 32'd1);
        chk("restart_cnt", 32'(if64.bit_count), 32'd0);

        // Mid-RUN restart with coincident bit_valid: bit dropped
        for (int i = 0; i < 5; i++) begin
            push_bit(2, bits5[i]);
            chk($sformatf("mid_sig%0d", i), 32'(if64.signature), 32'(sig5[i]));
        end
        chk("mid_cnt5", 32'(if64.bit_count), 32'd5);
        start_v[2] = 1'b1;
        push_bit(2, 1'b1);
        start_v[2] = 1'b0;
        chk("coinc_cnt", 32'(if64.bit_count), 32'd0);
        chk("coinc_sig", 32'(if64.signature), 32'h00);
        chk("coinc_busy", 32'(if64.busy), 32'd1);

        // Reset mid-RUN
        push_bit(2, 1'b1);
        push_bit(2, 1'b1);
        chk("pre_rst_sig", 32'(if64.signature), 32'h03);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_sig", 32'(if64.signature), 32'h00);
        chk("midrst_cnt", 32'(if64.bit_count), 32'd0);
        chk("midrst_busy", 32'(if64.busy), 32'd0);
        chk("midrst_done", 32'(if64.done), 32'd0);
        chk("midrst_pass", 32'(if64.pass), 32'd0);
        chk("midrst_n8_done", 32'(if8.done), 32'd0);

`ifdef BIST_SA_ABORT_EN
        // Abort after 3 bits freezes signature and count, returns to IDLE
        pulse_start(2);
        push_bit(2, 1'b1);
        push_bit(2, 1'b1);
        push_bit(2, 1'b0);
        abort64    = 1'b1;
        start_v[2] = 1'b1;
        tick();
        abort64    = 1'b0;
        start_v[2] = 1'b0;
        chk("abort_busy", 32'(if64.busy), 32'd0);
        chk("abort_done", 32'(if64.done), 32'd0);
        chk("abort_cnt", 32'(if64.bit_count), 32'd3);
        chk("abort_sig", 32'(if64.signature), 32'h06);
        push_bit(2, 1'b1);
        chk("abort_hold_sig", 32'(if64.signature), 32'h06);
        chk("abort_hold_cnt", 32'(if64.bit_count), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
